rv32_mod_dmem_sram: RTL and testbench
=====================================

Name: rv32_mod_dmem_sram

Overview:
Byte-enabled, word-organised data memory slave that sits directly downstream of the hart's load/store unit on the data bus. It consumes the unit's word-aligned request (req, wr, byte enables, address, write data) and returns a full 32-bit read word plus a single-cycle ack or err. Lane extraction and sign extension stay in the load/store unit. Configurable wait states let the core be exercised against slow memory.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, >= 2
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*DEPTH_WORDS
WAIT_STATES, 0, extra cycles inserted between request capture and access; 0..15

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
data_req  input  1  request valid; master holds it until ack/err
data_wr  input  1  1 = store, 0 = load
data_be  input  4  byte-lane enables; bit i = bits [8i+7:8i]
data_addr  input  32  byte address; bits [1:0] ignored (treated as 0)
data_wdata  input  32  store data, lane-aligned
data_rdata  output  32  full read word
data_ack  output  1  one-cycle pulse: transaction completed OK
data_err  output  1  one-cycle pulse: transaction rejected

Behaviour:
- States: IDLE, WAIT, ACCESS, RESP.
- Reset (reset low, asynchronous): state=IDLE, data_ack=0, data_err=0, data_rdata=0, wait counter=0, captured fields cleared. Memory contents are not reset.
- IDLE: when data_req=1, capture wr, be, word index, wdata and an in-range flag. In range means BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS. Go to WAIT if WAIT_STATES>0, else ACCESS.
- WAIT: counter loads WAIT_STATES-1 on entry and decrements each cycle. Exit to ACCESS when it reaches 0, so WAIT lasts exactly WAIT_STATES cycles.
- ACCESS (one cycle):
  - In range, store: write each lane whose be bit is 1; other lanes are unchanged. be=0 is a legal no-op and still acks.
  - In range, load: register the full word into data_rdata.
  - Out of range: no memory access.
  - Always go to RESP.
- RESP (one cycle): data_ack=1 if in range, else data_err=1. Never both. Next state is IDLE.
- data_ack and data_err are registered outputs and are 0 in every state except RESP.
- Latency: request sampled in IDLE at cycle 0. ack/err is high during cycle WAIT_STATES+2 and for that cycle only.
- Throughput: the next request is sampled in the IDLE cycle after RESP. Minimum cost is WAIT_STATES+3 cycles per access.
- data_rdata updates only in ACCESS of an in-range load. It holds its value through stores, errors and idle cycles.
- Inputs are ignored outside IDLE. Deasserting data_req mid-transaction does not abort it; the response is still issued.
- Reset asserted mid-transaction: return to IDLE with no response.
  - If reset is asserted before the ACCESS clock edge, no write occurs.
  - A write committed at the ACCESS edge persists.
- Word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits after the range check.
- Read-after-write to the same word on back-to-back transactions returns the new data; no bypass is needed because ACCESS is serialised.
- Memory is inferred as a single-port synchronous RAM with byte-write enables. No read-during-write behaviour is required.

Test Plan:
- Reset with WAIT_STATES=0, then store addr=0x10, be=1111, wdata=0xDEADBEEF -> ack high exactly in cycle 2, err=0. Follow with load addr=0x10 -> data_rdata=0xDEADBEEF with ack in cycle 2.
- Partial store: addr=0x10, be=0100, wdata=0x00AA0000 over 0xDEADBEEF -> load returns 0xDEAABEEF. Store with be=0000 -> ack, word unchanged.
- DEPTH_WORDS=1024, BASE_ADDR=0: load addr=0x1000 -> err pulse in cycle 2, ack=0, data_rdata unchanged. Store to 0xFFFC -> err, no memory word modified.
- WAIT_STATES=3: load -> ack only in cycle 5. Drop data_req in cycle 1 -> ack still in cycle 5. Data_req held high continuously for two loads -> second ack in cycle 11.
- Assert reset low during WAIT of a store (WAIT_STATES=2, cycle 2) -> ack/err never pulse, outputs 0 immediately. Subsequent load of that address returns the old value.
- Addr 0x13 with be=1000 -> treated as word 0x10; only bits [31:24] written. Verify ack and err are never high together across a randomised run of 1000 transactions.

Source files
------------

// File: rtl/rv32_mod_dmem_sram.sv
// Word-organised data memory slave with byte-lane writes and optional wait states.
// Ports: clk, reset (async active-low), data_req/wr/be/addr/wdata in; data_rdata/ack/err out.
module rv32_mod_dmem_sram #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ack,
    output logic        data_err
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WS_INIT =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t state;

    logic [3:0]    cnt;
    logic          wr_q;
    logic [3:0]    be_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          hit_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] word_addr;
    logic [31:0] offset;
    logic        hit;
    logic        unused_lsb;

    // Sub-word address bits never select anything: requests are word-aligned.
    assign word_addr  = {data_addr[31:2], 2'b00};
    assign unused_lsb = ^data_addr[1:0];

    // Addresses below the base wrap to a huge offset, so one unsigned
    // compare covers both ends of the window.
    assign offset = word_addr - BASE_ADDR;
    assign hit    = ({1'b0, offset} < SPAN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            wr_q       <= 1'b0;
            be_q       <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            hit_q      <= 1'b0;
            data_rdata <= 32'd0;
            data_ack   <= 1'b0;
            data_err   <= 1'b0;
        end else begin
            data_ack <= 1'b0;
            data_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (data_req) begin
                        wr_q    <= data_wr;
                        be_q    <= data_be;
                        idx_q   <= offset[AW+1:2];
                        wdata_q <= data_wdata;
                        hit_q   <= hit;
                        if (WAIT_STATES > 0) begin
                            cnt   <= WS_INIT;
                            state <= S_WAIT;
                        end else begin
                            state <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_ACCESS;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    if (hit_q && !wr_q) begin
                        data_rdata <= mem[idx_q];
                    end
                    if (hit_q) begin
                        data_ack <= 1'b1;
                    end else begin
                        data_err <= 1'b1;
                    end
                    state <= S_RESP;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage is not reset; a reset that lands before the ACCESS edge
    // leaves the state machine out of ACCESS, so no write happens.
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && hit_q && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32_mod_dmem_sram.sv
// Scoreboard bench for rv32_mod_dmem_sram: three instances with 0, 3 and 2 wait states.
// Driver pushes expected responses; a negedge monitor pops and compares them.
module tb_rv32_mod_dmem_sram;

    localparam int WSV [3] = '{0, 3, 2};

    typedef struct {
        int          d;
        int          cyc;
        bit          ack;
        bit          err;
        logic [31:0] rd;
    } exp_t;

    logic        clk;
    logic        rst_n [3];
    logic        req   [3];
    logic        wr    [3];
    logic [3:0]  be    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ack   [3];
    logic        err   [3];

    exp_t q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rv32_mod_dmem_sram #(
            .DEPTH_WORDS (1024),
            .BASE_ADDR   (32'h0000_0000),
            .WAIT_STATES (WSV[g])
        ) u_dut (
            .clk        (clk),
            .reset      (rst_n[g]),
            .data_req   (req[g]),
            .data_wr    (wr[g]),
            .data_be    (be[g]),
            .data_addr  (addr[g]),
            .data_wdata (wdata[g]),
            .data_rdata (rdata[g]),
            .data_ack   (ack[g]),
            .data_err   (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ack/err pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (ack[d] || err[d]) begin
                checks++;
                if (ack[d] && err[d]) begin
                    errors++;
                    $display("FAIL both d%0d cyc=%0d: ack and err high together, required one",
                             d, cyc);
                end
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected d%0d cyc=%0d: ack=%0b err=%0b, required no pulse",
                             d, cyc, ack[d], err[d]);
                end else begin
                    e = q.pop_front();
                    if (e.d != d || e.cyc != cyc || e.ack != ack[d] ||
                        e.err != err[d] || e.rd !== rdata[d]) begin
                        errors++;
                        $display("FAIL rsp d%0d: got cyc=%0d ack=%0b err=%0b rd=%h, required d%0d cyc=%0d ack=%0b err=%0b rd=%h",
                                 d, cyc, ack[d], err[d], rdata[d],
                                 e.d, e.cyc, e.ack, e.err, e.rd);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Called at a negedge with the target instance idle; returns at the
    // negedge of the next idle cycle.
    task automatic txn(input int d, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit eack, input logic [31:0] erd,
                       input bit hold);
        exp_t e;
        req[d]   = 1'b1;
        wr[d]    = w;
        be[d]    = b;
        addr[d]  = a;
        wdata[d] = wd;
        e.d   = d;
        e.cyc = cyc + WSV[d] + 2;
        e.ack = eack;
        e.err = !eack;
        e.rd  = erd;
        q.push_back(e);
        @(negedge clk);
        if (!hold) begin
            req[d]   = 1'b0;
            wr[d]    = 1'b0;
            be[d]    = 4'h0;
            addr[d]  = 32'h0;
            wdata[d] = 32'h0;
        end
        repeat (WSV[d] + 2) @(negedge clk);
    endtask

    task automatic drop(input int d);
        req[d]   = 1'b0;
        wr[d]    = 1'b0;
        be[d]    = 4'h0;
        addr[d]  = 32'h0;
        wdata[d] = 32'h0;
    endtask

    logic [31:0] mm [16];
    logic [31:0] rdm;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  b;
    bit          w;
    bit          oob;
    int          wi;

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0;
            drop(d);
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_ack d%0d", d), 32'(ack[d]), 32'h0);
            chk($sformatf("rst_err d%0d", d), 32'(err[d]), 32'h0);
            chk($sformatf("rst_rdata d%0d", d), rdata[d], 32'h0);
            rst_n[d] = 1'b1;
        end
        repeat (2) @(negedge clk);

        // Zero wait states: full, partial and empty byte enables.
        txn(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0);
        txn(0, 0, 4'hF, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0);
        txn(0, 1, 4'h4, 32'h10, 32'h00AA0000, 1, 32'hDEADBEEF, 0);
        txn(0, 0, 4'hF, 32'h10, 32'h0, 1, 32'hDEAABEEF, 0);
        txn(0, 1, 4'h0, 32'h10, 32'hFFFFFFFF, 1, 32'hDEAABEEF, 0);
        txn(0, 0, 4'hF, 32'h10, 32'h0, 1, 32'hDEAABEEF, 0);
        // Last word, then out-of-range accesses that would alias onto it.
        txn(0, 1, 4'hF, 32'hFFC, 32'h12345678, 1, 32'hDEAABEEF, 0);
        txn(0, 0, 4'hF, 32'h1000, 32'h0, 0, 32'hDEAABEEF, 0);
        txn(0, 1, 4'hF, 32'hFFFC, 32'hCAFEF00D, 0, 32'hDEAABEEF, 0);
        txn(0, 0, 4'hF, 32'hFFC, 32'h0, 1, 32'h12345678, 0);
        // Unaligned address selects the containing word.
        txn(0, 1, 4'h8, 32'h13, 32'h55000000, 1, 32'h12345678, 0);
        txn(0, 0, 4'hF, 32'h10, 32'h0, 1, 32'h55AABEEF, 0);
        txn(0, 0, 4'hF, 32'h11, 32'h0, 1, 32'h55AABEEF, 0);
        txn(0, 1, 4'hF, 32'h0, 32'h0BADC0DE, 1, 32'h55AABEEF, 0);
        txn(0, 0, 4'hF, 32'h0, 32'h0, 1, 32'h0BADC0DE, 0);

        // Three wait states: latency, early req drop, held req.
        txn(1, 1, 4'hF, 32'h40, 32'hA5A5A5A5, 1, 32'h0, 0);
        txn(1, 0, 4'hF, 32'h40, 32'h0, 1, 32'hA5A5A5A5, 0);
        txn(1, 1, 4'hF, 32'h44, 32'h5A5A5A5A, 1, 32'hA5A5A5A5, 0);
        txn(1, 0, 4'hF, 32'h44, 32'h0, 1, 32'h5A5A5A5A, 1);
        txn(1, 0, 4'hF, 32'h44, 32'h0, 1, 32'h5A5A5A5A, 0);

        // Two wait states: reset during WAIT aborts the store.
        txn(2, 1, 4'hF, 32'h20, 32'h11111111, 1, 32'h0, 0);
        txn(2, 0, 4'hF, 32'h20, 32'h0, 1, 32'h11111111, 0);
        req[2] = 1'b1;  wr[2] = 1'b1;  be[2] = 4'hF;
        addr[2] = 32'h20;  wdata[2] = 32'h22222222;
        @(negedge clk);
        drop(2);
        @(negedge clk);
        rst_n[2] = 1'b0;
        #1;
        chk("abort_ack", 32'(ack[2]), 32'h0);
        chk("abort_err", 32'(err[2]), 32'h0);
        chk("abort_rdata", rdata[2], 32'h0);
        repeat (2) @(negedge clk);
        rst_n[2] = 1'b1;
        @(negedge clk);
        txn(2, 0, 4'hF, 32'h20, 32'h0, 1, 32'h11111111, 0);

        // Reset landing in RESP: the write already committed stays.
        req[2] = 1'b1;  wr[2] = 1'b1;  be[2] = 4'hF;
        addr[2] = 32'h24;  wdata[2] = 32'h33333333;
        @(negedge clk);
        drop(2);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n[2] = 1'b0;
        #1;
        chk("late_rst_ack", 32'(ack[2]), 32'h0);
        repeat (2) @(negedge clk);
        rst_n[2] = 1'b1;
        @(negedge clk);
        txn(2, 0, 4'hF, 32'h24, 32'h0, 1, 32'h33333333, 0);

        // Randomised traffic on a small in-range window plus aliasing misses.
        rdm = 32'h0BADC0DE;
        for (int i = 0; i < 16; i++) begin
            mm[i] = $urandom;
            txn(0, 1, 4'hF, 32'h100 + 32'(i * 4), mm[i], 1, rdm, 0);
        end
        for (int n = 0; n < 1000; n++) begin
            oob = ($urandom_range(0, 4) == 0);
            wi  = $urandom_range(0, 15);
            w   = 1'($urandom_range(0, 1));
            b   = 4'($urandom);
            wd  = $urandom;
            if (!oob) begin
                a = 32'h100 + 32'(wi * 4) + 32'($urandom_range(0, 3));
            end else if ($urandom_range(0, 1) == 0) begin
                a = 32'h1100 + 32'(wi * 4);
            end else begin
                a = 32'hFFFF_0100 + 32'(wi * 4);
            end
            if (!oob) begin
                if (w) begin
                    for (int k = 0; k < 4; k++) begin
                        if (b[k]) mm[wi][8*k +: 8] = wd[8*k +: 8];
                    end
                end else begin
                    rdm = mm[wi];
                end
            end
            txn(0, w, b, a, wd, !oob, rdm, 0);
        end

        repeat (4) @(negedge clk);
        chk("pending_rsp", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
